// File: rtl/slot_reel_engine.sv
// slot_reel_engine: three LFSR-driven reels with a staggered stop, match evaluation and a win flag
module slot_reel_engine #(
    parameter int SYM_W    = 3,
    parameter int TICK_DIV = 4,
    parameter int STOP_GAP = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       state,
    output logic [SYM_W-1:0] reel0,
    output logic [SYM_W-1:0] reel1,
    output logic [SYM_W-1:0] reel2,
    output logic             settled,
    output logic [1:0]       match_count,
    output logic             win_flag
);
    localparam int TW = $clog2(TICK_DIV + 1);
    localparam int GW = $clog2(STOP_GAP + 1);
    localparam logic [1:0] G_SET = 2'b00;
    localparam logic [1:0] G_RUN = 2'b01;

    typedef enum logic [2:0] {IDLE, SPIN, STAG, EVAL, HOLD} fsm_t;

    fsm_t             fsm_q, fsm_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [TW-1:0]    tick_q, tick_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic             frz1_q, frz1_d;
    logic [SYM_W-1:0] reel_q [3];
    logic [SYM_W-1:0] reel_d [3];
    logic             settled_q, settled_d;
    logic [1:0]       match_q, match_d;
    logic             win_q, win_d;
    logic             tick_hit, gap_hit;
    logic [2:0]       adv;

    assign reel0       = reel_q[0];
    assign reel1       = reel_q[1];
    assign reel2       = reel_q[2];
    assign settled     = settled_q;
    assign match_count = match_q;
    assign win_flag    = win_q;

    // Next-state: free-running LFSR, tick/gap counters, reel stepping and the spin/stop/evaluate sequence
    always_comb begin
        fsm_d     = fsm_q;
        lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        tick_hit  = tick_q == TW'(TICK_DIV - 1);
        gap_hit   = gap_q == GW'(STOP_GAP - 1);
        tick_d    = tick_hit ? '0 : tick_q + TW'(1);
        gap_d     = '0;
        frz1_d    = frz1_q;
        adv       = '0;
        settled_d = settled_q;
        match_d   = match_q;
        win_d     = win_q;
        case (fsm_q)
            IDLE: begin
                tick_d = '0;
                if (state == G_RUN) fsm_d = SPIN;
            end
            SPIN: begin
                frz1_d = 1'b0;
                if (state == G_SET) fsm_d = IDLE;
                else begin
                    adv = {3{tick_hit}};
                    if (state[1]) begin
                        fsm_d  = STAG;
                        adv[0] = 1'b0;
                    end
                end
            end
            STAG: begin
                gap_d = gap_hit ? '0 : gap_q + GW'(1);
                if (state == G_SET) fsm_d = IDLE;
                else begin
                    adv[1] = tick_hit && !frz1_q && !gap_hit;
                    adv[2] = tick_hit && !(gap_hit && frz1_q);
                    if (gap_hit) begin
                        frz1_d = 1'b1;
                        if (frz1_q) fsm_d = EVAL;
                    end
                end
            end
            EVAL: begin
                win_d     = reel_q[0] == reel_q[1] && reel_q[1] == reel_q[2];
                match_d   = win_d ? 2'd3 :
                            (reel_q[0] == reel_q[1] || reel_q[1] == reel_q[2] || reel_q[0] == reel_q[2]) ? 2'd2 : 2'd0;
                settled_d = 1'b1;
                fsm_d     = HOLD;
            end
            HOLD: begin
                if (state == G_SET) begin
                    fsm_d     = IDLE;
                    settled_d = 1'b0;
                    match_d   = 2'd0;
                    win_d     = 1'b0;
                end
            end
            default: fsm_d = IDLE;
        endcase
        for (int i = 0; i < 3; i++)
            reel_d[i] = adv[i] ? reel_q[i] + SYM_W'(1) + SYM_W'(lfsr_q[i]) : reel_q[i];
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q     <= IDLE;
            lfsr_q    <= 16'hACE1;
            tick_q    <= '0;
            gap_q     <= '0;
            frz1_q    <= 1'b0;
            settled_q <= 1'b0;
            match_q   <= 2'd0;
            win_q     <= 1'b0;
            for (int i = 0; i < 3; i++) reel_q[i] <= '0;
        end else begin
            fsm_q     <= fsm_d;
            lfsr_q    <= lfsr_d;
            tick_q    <= tick_d;
            gap_q     <= gap_d;
            frz1_q    <= frz1_d;
            settled_q <= settled_d;
            match_q   <= match_d;
            win_q     <= win_d;
            for (int i = 0; i < 3; i++) reel_q[i] <= reel_d[i];
        end
    end
endmodule

// File: tb/tb_slot_reel_engine.sv
// tb_slot_reel_engine: randomized and directed checks against a timeline-based reel model
module tb_slot_reel_engine;
    localparam int TD = 4;
    localparam int G  = 8;
    localparam int BIG = 32'h7fffffff;
    localparam logic [1:0] SET = 2'b00, RUN = 2'b01, STOP = 2'b10, WIN = 2'b11;

    typedef struct packed {
        logic [15:0]     lfsr;
        logic [2:0][2:0] r;
        int              ph;
        int              j;
        int              k;
        int              e;
        logic            set;
        logic [1:0]      mc;
        logic            win;
    } mst_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] state;
    logic [2:0] reel0, reel1, reel2;
    logic       settled, win_flag;
    logic [1:0] match_count;
    int         vectors = 0;
    int         miscompares = 0;
    mst_t       m;

    slot_reel_engine dut (
        .clk(clk), .rst(rst), .state(state),
        .reel0(reel0), .reel1(reel1), .reel2(reel2),
        .settled(settled), .match_count(match_count), .win_flag(win_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic mst_t mreset();
        mst_t t = '0;
        t.lfsr = 16'hACE1;
        return t;
    endfunction

    // phases: 0 idle, 1 spinning, 2 stopping, 4 evaluating, 3 showing result
    function automatic mst_t mstep(input mst_t c, input logic [1:0] s);
        mst_t n = c;
        int e = c.e + 1;
        int fz;
        logic all3;
        n.e = e;
        for (int i = 0; i < 3; i++) begin
            fz = (c.ph == 1 && s[1]) ? e + i * G : (c.ph == 2 ? c.k + i * G : BIG);
            if ((c.ph == 1 || c.ph == 2) && s != SET && e > c.j && (e - c.j) % TD == 0 && e < fz)
                n.r[i] = c.r[i] + 3'd1 + {2'b0, c.lfsr[i]};
        end
        all3 = c.r[0] == c.r[1] && c.r[1] == c.r[2];
        case (c.ph)
            0: if (s == RUN) begin n.ph = 1; n.j = e; end
            1: if (s == SET) n.ph = 0; else if (s[1]) begin n.ph = 2; n.k = e; end
            2: if (s == SET) n.ph = 0; else if (e == c.k + 2 * G) n.ph = 4;
            4: begin
                n.win = all3;
                n.mc  = all3 ? 2'd3 : (c.r[0] == c.r[1] || c.r[1] == c.r[2] || c.r[0] == c.r[2]) ? 2'd2 : 2'd0;
                n.set = 1'b1;
                n.ph  = 3;
            end
            3: if (s == SET) begin n.ph = 0; n.set = 0; n.mc = 0; n.win = 0; end
            default: n.ph = 0;
        endcase
        n.lfsr = {c.lfsr[14:0], c.lfsr[15] ^ c.lfsr[13] ^ c.lfsr[12] ^ c.lfsr[10]};
        return n;
    endfunction

    function automatic logic [8:0] predict(input mst_t c, input int p, input int l);
        mst_t t = c;
        for (int i = 0; i < p; i++) t = mstep(t, SET);
        for (int i = 0; i < l; i++) t = mstep(t, RUN);
        for (int i = 0; i < 2 * G + 2; i++) t = mstep(t, STOP);
        return t.r;
    endfunction

    task automatic step(input logic [1:0] s);
        state = s;
        @(posedge clk);
        m = mstep(m, s);
        #1;
        chk("reel0", reel0, m.r[0]);
        chk("reel1", reel1, m.r[1]);
        chk("reel2", reel2, m.r[2]);
        chk("settled", settled, m.set);
        chk("match_count", match_count, m.mc);
        chk("win_flag", win_flag, m.win);
    endtask

    task automatic run_to(input logic [8:0] target);
        int fp = -1, fl = -1;
        for (int p = 0; p < 128 && fp < 0; p++)
            for (int l = 4; l < 69 && fp < 0; l++)
                if (predict(m, p, l) == target) begin fp = p; fl = l; end
        chk("target_found", int'(fp >= 0), 1);
        if (fp < 0) fp = 0;
        if (fl < 0) fl = 4;
        repeat (fp) step(SET);
        repeat (fl) step(RUN);
        repeat (2 * G + 2) step(STOP);
    endtask

    initial begin
        int cnt [3];
        logic [2:0] prv [3];
        logic [2:0] r0k, r1c, r2c;
        int winseen;
        int pad, rl, sl, ab;
        rst = 1'b0;
        state = SET;
        m = mreset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_reel0", reel0, 0);
        chk("rst_settled", settled, 0);
        rst = 1'b1;
        repeat (3) step(SET);
        step(WIN);
        step(WIN);

        // 40 cycles of RUN after entry: ten steps on every reel
        step(RUN);
        for (int i = 0; i < 3; i++) cnt[i] = 0;
        prv[0] = reel0; prv[1] = reel1; prv[2] = reel2;
        for (int c = 0; c < 40; c++) begin
            step(RUN);
            if (reel0 != prv[0]) cnt[0]++;
            if (reel1 != prv[1]) cnt[1]++;
            if (reel2 != prv[2]) cnt[2]++;
            prv[0] = reel0; prv[1] = reel1; prv[2] = reel2;
        end
        chk("steps_reel0", cnt[0], 10);
        chk("steps_reel1", cnt[1], 10);
        chk("steps_reel2", cnt[2], 10);

        // staggered stop timing
        step(STOP);
        r0k = reel0;
        r1c = '0;
        r2c = '0;
        for (int i = 1; i <= 2 * G + 1; i++) begin
            step(STOP);
            if (i == G) r1c = reel1;
            if (i == 2 * G) begin
                r2c = reel2;
                chk("settled_early", settled, 0);
            end
        end
        chk("settled_k17", settled, 1);
        chk("reel0_frozen", reel0, r0k);
        chk("reel1_frozen", reel1, r1c);
        chk("reel2_frozen", reel2, r2c);
        step(SET);
        chk("clear_settled", settled, 0);

        // async reset mid-stagger
        repeat (10) step(RUN);
        repeat (5) step(STOP);
        #2 rst = 1'b0;
        #1;
        m = mreset();
        chk("arst_reel0", reel0, 0);
        chk("arst_reel1", reel1, 0);
        chk("arst_reel2", reel2, 0);
        chk("arst_settled", settled, 0);
        chk("arst_match", match_count, 0);
        chk("arst_win", win_flag, 0);
        chk("arst_lfsr", int'(dut.lfsr_q), 16'hACE1);
        state = SET;
        repeat (3) @(posedge clk);
        #1;
        chk("arst_lfsr_hold", int'(dut.lfsr_q), 16'hACE1);
        rst = 1'b1;
        repeat (2) step(SET);

        // jackpot 5,5,5 held through WIN, cleared by SET
        run_to({3'd5, 3'd5, 3'd5});
        chk("jackpot_match", match_count, 3);
        chk("jackpot_win", win_flag, 1);
        repeat (5) step(WIN);
        chk("win_hold", win_flag, 1);
        step(SET);
        chk("win_cleared", win_flag, 0);
        chk("match_cleared", match_count, 0);

        // pair 5,5,2
        run_to({3'd2, 3'd5, 3'd5});
        chk("pair_match", match_count, 2);
        chk("pair_win", win_flag, 0);
        chk("pair_settled", settled, 1);
        step(SET);

        // abort at k+5
        repeat (12) step(RUN);
        repeat (5) step(STOP);
        r0k = reel0;
        step(SET);
        chk("abort_reel0", reel0, r0k);
        chk("abort_settled", settled, 0);
        winseen = 0;
        for (int i = 0; i < 30; i++) begin
            step($urandom_range(0, 1) ? STOP : WIN);
            winseen |= int'(win_flag);
        end
        chk("abort_no_win", winseen, 0);

        // randomized episodes
        for (int ep = 0; ep < 15; ep++) begin
            pad = $urandom_range(0, 4);
            rl  = $urandom_range(2, 40);
            sl  = $urandom_range(1, 24);
            ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, sl - 1)) : -1;
            for (int i = 0; i < pad; i++) step($urandom_range(0, 1) ? SET : WIN);
            for (int i = 0; i < rl; i++) step(RUN);
            for (int i = 0; i < sl; i++) step(i == ab ? SET : ($urandom_range(0, 1) ? STOP : WIN));
            repeat (20) step(WIN);
            repeat (2) step(SET);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
